// File: rtl/fre_gen.sv
// Programmable square-wave generator: a restoring divider turns a requested
// frequency into a half-period count, and a counter then toggles sig_out.
module fre_gen #(
    parameter int unsigned CLK_HALF = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [29:0] fre_in,
    output logic        sig_out,
    output logic        busy,
    output logic        running,
    output logic        err,
    output logic [29:0] half_per
);

    localparam logic [29:0] DVD = 30'(CLK_HALF);

    typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

    state_t      state_q, state_d;
    logic [29:0] fre_q, fre_d;
    logic [29:0] dvd_q, dvd_d;
    logic [29:0] rem_q, rem_d;
    logic [29:0] quo_q, quo_d;
    logic [4:0]  bit_q, bit_d;
    logic [29:0] cnt_q, cnt_d;
    logic [29:0] half_per_q, half_per_d;
    logic        sig_q, sig_d;
    logic        busy_q, busy_d;
    logic        running_q, running_d;
    logic        err_q, err_d;

    logic [30:0] rem_sh;
    logic [30:0] diff;
    logic        qbit;
    logic [29:0] quo_nxt;

    always_comb begin
        state_d    = state_q;
        fre_d      = fre_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        half_per_d = half_per_q;
        sig_d      = sig_q;
        busy_d     = busy_q;
        running_d  = running_q;
        err_d      = err_q;

        // One restoring step: bring down the next dividend bit, subtract if it fits.
        rem_sh  = {rem_q, dvd_q[29]};
        diff    = rem_sh - {1'b0, fre_q};
        qbit    = (rem_sh >= {1'b0, fre_q});
        quo_nxt = {quo_q[28:0], qbit};

        case (state_q)
            IDLE, RUN: begin
                if (load) begin
                    fre_d     = fre_in;
                    err_d     = 1'b0;
                    sig_d     = 1'b0;
                    running_d = 1'b0;
                    cnt_d     = '0;
                    if (fre_in == '0) begin
                        err_d      = 1'b1;
                        half_per_d = '0;
                        state_d    = IDLE;
                    end else begin
                        state_d = DIV;
                        busy_d  = 1'b1;
                        dvd_d   = DVD;
                        rem_d   = '0;
                        quo_d   = '0;
                        bit_d   = '0;
                    end
                end else if (state_q == RUN) begin
                    if (cnt_q == half_per_q - 30'd1) begin
                        sig_d = ~sig_q;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 30'd1;
                    end
                end
            end
            DIV: begin
                rem_d = qbit ? diff[29:0] : rem_sh[29:0];
                dvd_d = {dvd_q[28:0], 1'b0};
                quo_d = quo_nxt;
                if (bit_q == 5'd29) begin
                    half_per_d = quo_nxt;
                    busy_d     = 1'b0;
                    if (quo_nxt == '0) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        running_d = 1'b1;
                        state_d   = RUN;
                    end
                end else begin
                    bit_d = bit_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fre_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            half_per_q <= '0;
            sig_q      <= 1'b0;
            busy_q     <= 1'b0;
            running_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fre_q      <= fre_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            bit_q      <= bit_d;
            cnt_q      <= cnt_d;
            half_per_q <= half_per_d;
            sig_q      <= sig_d;
            busy_q     <= busy_d;
            running_q  <= running_d;
            err_q      <= err_d;
        end
    end

    assign sig_out  = sig_q;
    assign busy     = busy_q;
    assign running  = running_q;
    assign err      = err_q;
    assign half_per = half_per_q;

endmodule

// File: tb/tb_fre_gen.sv
// Directed bench for fre_gen: divider latency, quotients, waveform timing,
// invalid requests, reload while running and asynchronous reset.
module tb_fre_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [29:0] fre_in = '0;
    logic        sig_out, busy, running, err;
    logic [29:0] half_per;

    int total = 0;
    int bad = 0;

    fre_gen dut (
        .clk(clk), .rst(rst), .load(load), .fre_in(fre_in),
        .sig_out(sig_out), .busy(busy), .running(running),
        .err(err), .half_per(half_per)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input logic [29:0] f);
        load   = 1'b1;
        fre_in = f;
        step();
        load   = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_sig(input logic lvl, output int n);
        n = 0;
        while (sig_out !== lvl && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_sig"}, sig_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_run"}, running, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_hp"}, half_per, 0);
    endtask

    // Load a valid frequency and check latency, quotient and waveform timing.
    task automatic run_case(input string tag, input logic [29:0] f, input int hp);
        int n;
        pulse_load(f);
        chk({tag, "_busy0"}, busy, 1);
        count_busy(n);
        chk({tag, "_busycyc"}, n, 30);
        chk({tag, "_running"}, running, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_hp"}, half_per, hp);
        wait_sig(1'b1, n);
        chk({tag, "_rise"}, n, hp);
        wait_sig(1'b0, n);
        chk({tag, "_high"}, n, hp);
        wait_sig(1'b1, n);
        chk({tag, "_low"}, n, hp);
    endtask

    initial begin
        int n;
        #1;
        chk_idle_zero("rst_hold");
        #40;
        rst = 1'b0;
        step();
        step();
        chk_idle_zero("post_rst");

        run_case("f1m", 30'd1_000_000, 25);

        // 25 MHz: toggles on every clock.
        pulse_load(30'd25_000_000);
        count_busy(n);
        chk("f25m_busycyc", n, 30);
        chk("f25m_hp", half_per, 1);
        chk("f25m_s0", sig_out, 0);
        step(); chk("f25m_s1", sig_out, 1);
        step(); chk("f25m_s2", sig_out, 0);
        step(); chk("f25m_s3", sig_out, 1);

        pulse_load(30'd3);
        count_busy(n);
        chk("f3_hp", half_per, 8_333_333);
        chk("f3_run", running, 1);

        // Zero request from RUN: error at once, no division.
        pulse_load(30'd0);
        chk("f0_err", err, 1);
        chk("f0_busy", busy, 0);
        chk("f0_run", running, 0);
        chk("f0_hp", half_per, 0);
        chk("f0_sig", sig_out, 0);
        step(); step();
        chk("f0_err_sticky", err, 1);
        chk("f0_busy_later", busy, 0);

        // Request above CLK_HALF: quotient zero.
        pulse_load(30'd30_000_000);
        chk("f30m_errclr", err, 0);
        count_busy(n);
        chk("f30m_busycyc", n, 30);
        chk("f30m_err", err, 1);
        chk("f30m_run", running, 0);
        chk("f30m_hp", half_per, 0);

        // Reload while running; a load mid-DIV must be ignored.
        pulse_load(30'd1_000_000);
        count_busy(n);
        wait_sig(1'b1, n);
        chk("rl_first_rise", n, 25);
        pulse_load(30'd2_000_000);
        chk("rl_sig_low", sig_out, 0);
        chk("rl_busy", busy, 1);
        chk("rl_run", running, 0);
        n = 0;
        while (busy && n < 100) begin
            if (n == 5) begin
                load   = 1'b1;
                fre_in = 30'd5;
            end else begin
                load = 1'b0;
            end
            step();
            n++;
        end
        load = 1'b0;
        chk("rl_busycyc", n, 30);
        chk("rl_hp", half_per, 12);
        chk("rl_running", running, 1);
        wait_sig(1'b1, n);
        chk("rl_rise", n, 12);
        wait_sig(1'b0, n);
        chk("rl_high", n, 12);
        wait_sig(1'b1, n);
        chk("rl_low", n, 12);

        // Asynchronous reset at DIV cycle 15.
        pulse_load(30'd1_000_000);
        repeat (14) step();
        chk("ar_busy_pre", busy, 1);
        #4;
        rst = 1'b1;
        #1;
        chk_idle_zero("ar_async");
        load   = 1'b1;
        fre_in = 30'd1_000_000;
        step();
        load = 1'b0;
        chk_idle_zero("ar_load_in_rst");
        rst = 1'b0;
        repeat (5) step();
        chk_idle_zero("ar_quiet");
        run_case("ar_f1m", 30'd1_000_000, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
